// File: rtl/float_to_fixed_pkg.sv
// Shared types for the float-to-fixed converter: IEEE-754 single-precision
// field layout, exponent/mantissa constants and operand classification.
package float_to_fixed_pkg;

  localparam int EXP_BIAS = 127;
  localparam int MAN_BITS = 23;

  typedef struct packed {
    logic                sign;
    logic [7:0]          exp;
    logic [MAN_BITS-1:0] man;
  } ieee_sp_t;

  typedef enum logic [1:0] {ZERO, NORMAL, INF, NAN} fclass_t;

  // Zero exponent covers both zero and denormals; these flush to zero.
  function automatic fclass_t classify(input ieee_sp_t f);
    fclass_t c;
    if (f.exp == 8'd0) begin
      c = ZERO;
    end else if (f.exp == 8'hFF) begin
      c = (f.man == '0) ? INF : NAN;
    end else begin
      c = NORMAL;
    end
    return c;
  endfunction

endpackage

// File: rtl/float_to_fixed_pipe_shift.sv
// f2f_shift: barrel shifter that places the 24-bit mantissa into a W-bit
// magnitude. Positive shift moves left, non-positive moves right. Overflow is
// decided from the shift amount and the bits that would leave the W-bit
// window, so no shifted-out bit can wrap into the result.
module f2f_shift #(
  parameter int unsigned W = 24
) (
  input  logic               [23:0]  mant_i,
  input  logic signed        [9:0]   shift_i,
  output logic               [W-1:0] mag_o,
  output logic                       guard_o,
  output logic                       sticky_o,
  output logic                       ovf_o
);

  logic [63:0] lwide;
  logic [47:0] rwide;
  logic [63:0] rmag;
  int          sh;
  int unsigned ramt;

  // Shift the mantissa and derive guard/sticky (right) or overflow (left).
  always_comb begin
    lwide    = '0;
    rwide    = '0;
    rmag     = '0;
    sh       = int'(shift_i);
    ramt     = 0;
    mag_o    = '0;
    guard_o  = 1'b0;
    sticky_o = 1'b0;
    ovf_o    = 1'b0;
    if (sh >= 0) begin
      if (sh >= int'(W)) begin
        ovf_o = |mant_i;
      end else begin
        lwide = {40'd0, mant_i} << sh[5:0];
        ovf_o = |lwide[63:W];
        mag_o = lwide[W-1:0];
      end
    end else begin
      // Beyond 48 every mantissa bit is already below the guard position.
      ramt     = (sh <= -48) ? 32'd48 : unsigned'(-sh);
      rwide    = {mant_i, 24'd0} >> ramt[5:0];
      rmag     = {40'd0, rwide[47:24]};
      ovf_o    = |rmag[63:W];
      mag_o    = rmag[W-1:0];
      guard_o  = rwide[23];
      sticky_o = (|rwide[22:0]) | ((sh <= -48) & (|mant_i));
    end
  end

endmodule

// File: rtl/float_to_fixed_pipe.sv
// float_to_fixed_pipe: 3-stage IEEE-754 single to signed fixed-point
// converter with valid/ready flow control on both sides.
//   S1 unpack/classify, S2 shift/round, S3 negate/saturate (output register).
// Optional feature macro: FLOAT2FIX_ROUND_EN selects round-to-nearest,
// ties away from zero; otherwise the magnitude is truncated toward zero.
module float_to_fixed_pipe
  import float_to_fixed_pkg::*;
#(
  parameter int unsigned FRACTIONAL_BITS = 22,
  parameter int unsigned INT_BITS        = 1
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [31:0]                           in_data,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [INT_BITS+FRACTIONAL_BITS:0]     out_data,
  output logic                                  out_ovf,
  output logic                                  out_nan
);

  localparam int unsigned W = INT_BITS + FRACTIONAL_BITS + 1;

  // Magnitude limits carry one extra bit so a rounding carry is still visible.
  localparam logic [W:0]   POS_LIM = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   NEG_LIM = {2'b01, {(W-1){1'b0}}};
  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};

  // Stage 1 registers
  logic                s1_valid_q;
  logic                s1_sign_q,  s1_sign_d;
  fclass_t             s1_cls_q,   s1_cls_d;
  logic [23:0]         s1_mant_q,  s1_mant_d;
  logic signed [9:0]   s1_shift_q, s1_shift_d;

  // Stage 2 registers
  logic                s2_valid_q;
  logic                s2_sign_q;
  fclass_t             s2_cls_q;
  logic [W:0]          s2_mag_q,   s2_mag_d;
  logic                s2_ovf_q;

  // Stage 3 (output) registers
  logic                out_valid_q;
  logic [W-1:0]        out_data_q, out_data_d;
  logic                out_ovf_q,  out_ovf_d;
  logic                out_nan_q,  out_nan_d;

  logic                adv1, adv2, adv3;
  ieee_sp_t            fin;
  logic [W-1:0]        sh_mag;
  logic                sh_guard, sh_sticky, sh_ovf;
  logic                round_inc;
  logic [W:0]          mag_neg;
  logic                unused_bits;

  // Stage k moves when it is empty or the stage after it moves.
  always_comb begin
    adv3 = !out_valid_q || out_ready;
    adv2 = !s2_valid_q || adv3;
    adv1 = !s1_valid_q || adv2;
  end

  assign in_ready  = adv1;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign out_nan   = out_nan_q;

  // S1: split the IEEE fields, classify and compute the signed shift amount.
  always_comb begin
    fin        = ieee_sp_t'(in_data);
    s1_sign_d  = fin.sign;
    s1_cls_d   = classify(fin);
    s1_mant_d  = {(fin.exp != 8'd0), fin.man};
    s1_shift_d = 10'(int'(fin.exp) - EXP_BIAS + int'(FRACTIONAL_BITS) - MAN_BITS);
  end

  f2f_shift #(
    .W (W)
  ) u_shift (
    .mant_i   (s1_mant_q),
    .shift_i  (s1_shift_q),
    .mag_o    (sh_mag),
    .guard_o  (sh_guard),
    .sticky_o (sh_sticky),
    .ovf_o    (sh_ovf)
  );

  // Ties-away rounding only needs the guard bit; sticky is kept for reuse.
  assign unused_bits = ^{sh_sticky, sh_guard};

`ifdef FLOAT2FIX_ROUND_EN
  assign round_inc = sh_guard;
`else
  assign round_inc = 1'b0;
`endif

  // S2: apply rounding to the magnitude; the extra top bit holds any carry.
  always_comb begin
    s2_mag_d = {1'b0, sh_mag} + {{W{1'b0}}, round_inc};
  end

  // S3: special-case handling, saturation against the signed limits, negate.
  always_comb begin
    out_data_d = '0;
    out_ovf_d  = 1'b0;
    out_nan_d  = 1'b0;
    mag_neg    = -s2_mag_q;
    case (s2_cls_q)
      ZERO: begin
      end
      NAN: begin
        out_nan_d = 1'b1;
      end
      INF: begin
        out_ovf_d  = 1'b1;
        out_data_d = s2_sign_q ? SAT_NEG : SAT_POS;
      end
      default: begin
        if (s2_ovf_q || (s2_mag_q > (s2_sign_q ? NEG_LIM : POS_LIM))) begin
          out_ovf_d  = 1'b1;
          out_data_d = s2_sign_q ? SAT_NEG : SAT_POS;
        end else begin
          out_data_d = s2_sign_q ? mag_neg[W-1:0] : s2_mag_q[W-1:0];
        end
      end
    endcase
  end

  // Pipeline registers; each stage loads only when it advances.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_cls_q    <= ZERO;
      s1_mant_q   <= '0;
      s1_shift_q  <= '0;
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_cls_q    <= ZERO;
      s2_mag_q    <= '0;
      s2_ovf_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_nan_q   <= 1'b0;
    end else begin
      if (adv1) begin
        s1_valid_q <= in_valid;
        s1_sign_q  <= s1_sign_d;
        s1_cls_q   <= s1_cls_d;
        s1_mant_q  <= s1_mant_d;
        s1_shift_q <= s1_shift_d;
      end
      if (adv2) begin
        s2_valid_q <= s1_valid_q;
        s2_sign_q  <= s1_sign_q;
        s2_cls_q   <= s1_cls_q;
        s2_mag_q   <= s2_mag_d;
        s2_ovf_q   <= sh_ovf;
      end
      if (adv3) begin
        out_valid_q <= s2_valid_q;
        if (s2_valid_q) begin
          out_data_q <= out_data_d;
          out_ovf_q  <= out_ovf_d;
          out_nan_q  <= out_nan_d;
        end
      end
    end
  end

endmodule

// File: doc/float_to_fixed_pipe.md
FLOAT_TO_FIXED_PIPE -- requirements
Module: float_to_fixed_pipe

Interface
REQ-001 SHALL have parameter FRACTIONAL_BITS, default 22, fractional bits of the output (legal 1..29).
REQ-002 SHALL have parameter INT_BITS, default 1, integer bits excluding sign (legal 0..8); W = INT_BITS+FRACTIONAL_BITS+1, W <= 32.
REQ-003 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  in_data is valid.
REQ-006 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-007 SHALL have port in_data  input  32  IEEE-754 single-precision operand.
REQ-008 SHALL have port out_valid  output  1  out_data/flags are valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts output this cycle.
REQ-010 SHALL have port out_data  output  W  signed two's-complement fixed-point result, FRACTIONAL_BITS fraction bits.
REQ-011 SHALL have port out_ovf  output  1  result saturated.
REQ-012 SHALL have port out_nan  output  1  operand was NaN.

Function
REQ-013 SHALL convert value (-1)^s * 1.m * 2^(e-127) to round_or_trunc(value * 2^FRACTIONAL_BITS) using a 24-bit mantissa with hidden one and shift = e-127+FRACTIONAL_BITS-23 (left if positive, right otherwise).
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 shift/round, S3 negate/saturate/register; latency 3 cycles with no stall, throughput 1 per cycle.
REQ-015 SHALL transfer input when in_valid && in_ready and output when out_valid && out_ready.
REQ-016 SHALL advance stage k when stage k is empty or stage k+1 advances; in_ready = !S1_valid || S1 advances (combinational, no in_valid dependency).
REQ-017 SHALL hold out_data, out_ovf, out_nan stable while out_valid && !out_ready.
REQ-018 SHALL flush e==0 (zero, denormal) to 0, ovf=0, nan=0.
REQ-019 SHALL saturate positive magnitudes > 2^(W-1)-1 to 2^(W-1)-1 and negative magnitudes > 2^(W-1) to -2^(W-1), asserting out_ovf; -2^(W-1) exactly SHALL NOT set out_ovf.
REQ-020 SHALL treat e==255, m==0 (infinity) as saturation per sign with out_ovf=1.
REQ-021 SHALL output 0 with out_nan=1, out_ovf=0 for e==255, m!=0.
REQ-022 SHALL detect left-shift overflow before shifting (no wrap-around of shifted bits), including shift amounts >= W.
REQ-023 SHALL produce 0 (not -0 artefacts) for right shifts >= 25 in truncate mode.
REQ-024 SHALL accept simultaneous output pop and input push with a full pipeline without bubbles.

Reset
REQ-025 SHALL, on reset, clear all stage valids, set out_valid=0, out_data=0, out_ovf=0, out_nan=0; in_ready=1 the cycle after reset deasserts.
REQ-026 SHALL discard in-flight operands when reset asserts mid-operation; no output produced for them.

Configuration
REQ-027 SHALL, with FLOAT2FIX_ROUND_EN defined, round to nearest with ties away from zero on magnitude before negation; rounding carry SHALL feed saturation check.
REQ-028 SHALL, without FLOAT2FIX_ROUND_EN, truncate magnitude toward zero; latency unchanged.

Structure
REQ-029 SHALL place in package float_to_fixed_pkg: IEEE field typedef (sign, exp[7:0], man[22:0]), EXP_BIAS=127, MAN_BITS=23, class enum {ZERO, NORMAL, INF, NAN}.
REQ-030 SHALL use one sub-module, f2f_shift, a parametrised barrel shifter returning shifted magnitude, guard/sticky bits and overflow.

Verification (FRACTIONAL_BITS=22, INT_BITS=1, W=24)
REQ-031 SHALL check 0x3F800000 (1.0) -> 0x400000, then 0xBF000000 (-0.5) -> 0xE00000, out_valid 3 cycles after each accept, flags 0.
REQ-032 SHALL check 0x40000000 (2.0) -> 0x7FFFFF ovf=1; 0xC0000000 (-2.0) -> 0x800000 ovf=0; 0x7F800000 -> 0x7FFFFF ovf=1.
REQ-033 SHALL check 0x34800000 (2^-22) -> 0x000001; 0x34000000 (2^-23) -> 0x000001 with FLOAT2FIX_ROUND_EN, 0x000000 without.
REQ-034 SHALL check 0x7FC00000 -> 0x000000 nan=1; 0x00000001 (denormal) -> 0x000000 flags 0.
REQ-035 SHALL stream 16 back-to-back operands with out_ready low for cycles 5-8: in_ready falls within one cycle of pipeline full, results arrive in order, none lost or duplicated, out_data stable while stalled.
REQ-036 SHALL assert reset for one cycle with 3 operands in flight: out_valid=0 next cycle, no stale outputs afterwards, next operand emerges after 3 cycles.
